ysyx_22050710_ifu_pcgen: RTL and testbench
==========================================

Name: ysyx_22050710_ifu_pcgen

Overview:
- Instruction-fetch-stage PC generator and fetch sequencer, in the IF stage.
- It is the receiving end of the ID-stage branch/redirect bus (br_sel / br_target). It owns the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready request/response handshake, and delivers {pc, inst} to ID through a one-entry output buffer.
- Redirects flush the buffer and cancel any in-flight fetch.

Parameters:
- PC_WD, 64, width of PC and fetch address.
- INST_WD, 32, instruction word width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_br_sel  input  1  redirect request from ID (branch/jump/ecall/mret); one-cycle pulse.
- i_br_target  input  PC_WD  redirect target; valid when i_br_sel=1.
- o_ireq_valid  output  1  fetch request valid.
- i_ireq_ready  input  1  memory accepts request.
- o_ireq_addr  output  PC_WD  fetch address (= current PC register).
- i_irsp_valid  input  1  fetch response valid.
- o_irsp_ready  output  1  IFU accepts response.
- i_irsp_data  input  INST_WD  fetched instruction.
- o_if_valid  output  1  output buffer holds a valid {pc, inst} for ID.
- i_id_ready  input  1  ID accepts the buffer this cycle (allowin).
- o_if_pc  output  PC_WD  PC of buffered instruction.
- o_if_inst  output  INST_WD  buffered instruction.

Behaviour:
- State register: IDLE, REQ, WAIT. Other registers: pc, drop (cancel flag), out_valid, out_pc, out_inst.
- Reset (i_rst=1 at an edge, any state, including mid-fetch):
  - state=IDLE, pc=RESET_PC, drop=0, out_valid=0, out_pc=0, out_inst=0.
  - All outputs read 0 in IDLE.
  - The memory side shares i_rst; no response survives reset.
- IDLE: goes to REQ unconditionally next cycle. o_ireq_valid=0, o_irsp_ready=0.
- REQ:
  - o_ireq_valid=1, o_ireq_addr=pc.
  - On i_ireq_ready=1, go to WAIT.
- WAIT:
  - o_ireq_valid=0.
  - o_irsp_ready = drop | ~out_valid | i_id_ready. The buffer is free or draining this cycle.
  - On response handshake with drop=1: discard the data, drop<=0, go to REQ. pc is already the redirect target.
  - On response handshake with drop=0: out_pc<=pc, out_inst<=i_irsp_data, out_valid<=1, pc<=pc+4 (mod 2^PC_WD, wraps), go to REQ.
- Exactly one outstanding request at a time. A new request is never issued before the previous response handshake. Best-case throughput is one instruction per 2 cycles (REQ then WAIT) with a zero-wait memory.
- Output drain: if out_valid & i_id_ready and no new load this cycle, out_valid<=0. A simultaneous drain and load keeps out_valid=1 with the new contents.
- Redirect (i_br_sel=1) has priority over all other updates except reset:
  - pc<=i_br_target; out_valid<=0, so any buffered instruction is flushed even if i_id_ready=1.
  - In REQ without a request handshake this cycle: stay in REQ. o_ireq_addr shows the new target next cycle. The address changes while valid is held; only a redirect may do this.
  - In REQ with a request handshake this cycle: the old-PC request is in flight. Go to WAIT with drop<=1.
  - In WAIT with no response handshake this cycle: drop<=1, stay in WAIT.
  - In WAIT with a response handshake this cycle: the response is discarded, drop<=0, go to REQ.
  - In IDLE: pc<=i_br_target; the first fetch uses the target.
  - A redirect while drop=1 updates pc; drop stays 1.
- pc+4 and i_br_target are used unchanged. No alignment check; misaligned targets are ID's concern.
- o_if_pc/o_if_inst hold their values while out_valid=1 and i_id_ready=0 (stall). They are don't-care when o_if_valid=0, but registers keep their last value.

Test Plan:
- Reset, then zero-wait memory returning inst=0x00000013 for every address, with i_id_ready=1. Required: o_ireq_addr sequence 0x80000000, 0x80000004, 0x80000008; o_if_valid every other cycle; o_if_pc matches each address.
- ID stall: hold i_id_ready=0 after the first instruction is buffered; memory answers 0x80000004 at once. Required: o_irsp_ready=0, out holds pc=0x80000000 unchanged. Release i_id_ready: response accepted the same cycle, out becomes 0x80000004/its inst.
- Redirect during WAIT: request 0x80000008 accepted; pulse i_br_sel with target 0x80001000; response for 0x80000008 arrives 3 cycles later. Required: response discarded (o_if_valid stays 0), next request address is 0x80001000.
- Redirect colliding with request accept: i_br_sel=1 with target 0x80002000 and i_ireq_ready=1 in REQ at pc=0x80000010. Required: WAIT with drop=1, the 0x80000010 response is discarded, next request is 0x80002000.
- Redirect while buffer valid, with i_id_ready=1 the same cycle: o_if_valid=0 next cycle; no instruction from the old path reaches ID afterwards.
- Reset asserted in WAIT with a buffer valid. Required: next cycle state=IDLE, o_if_valid=0, o_ireq_valid=0; the cycle after, o_ireq_valid=1 with addr 0x80000000. PC wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC, fetch completes, next address 0x0.

Source files
------------

// File: rtl/ysyx_22050710_ifu_pcgen.sv
// IF-stage PC generator: owns the fetch PC, issues one imem request at a
// time and hands {pc, inst} to ID through a one-entry buffer.
module ysyx_22050710_ifu_pcgen #(
    parameter int               PC_WD    = 64,
    parameter int               INST_WD  = 32,
    parameter logic [PC_WD-1:0] RESET_PC = PC_WD'(64'h8000_0000)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_br_sel,
    input  logic [PC_WD-1:0]   i_br_target,
    output logic               o_ireq_valid,
    input  logic               i_ireq_ready,
    output logic [PC_WD-1:0]   o_ireq_addr,
    input  logic               i_irsp_valid,
    output logic               o_irsp_ready,
    input  logic [INST_WD-1:0] i_irsp_data,
    output logic               o_if_valid,
    input  logic               i_id_ready,
    output logic [PC_WD-1:0]   o_if_pc,
    output logic [INST_WD-1:0] o_if_inst
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PC_WD-1:0]   pc_q;
    logic               drop_q;
    logic               out_valid_q;
    logic [PC_WD-1:0]   out_pc_q;
    logic [INST_WD-1:0] out_inst_q;

    logic req_hs;
    logic rsp_hs;
    logic load;

    assign req_hs = o_ireq_valid & i_ireq_ready;
    assign rsp_hs = o_irsp_ready & i_irsp_valid;
    // a response arriving alongside a redirect belongs to the old path
    assign load   = rsp_hs & ~drop_q & ~i_br_sel;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (req_hs) state_d = WAIT;
            WAIT:    if (rsp_hs) state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ireq_valid = 1'b0;
        o_irsp_ready = 1'b0;
        o_ireq_addr  = '0;
        unique case (state_q)
            IDLE: ;
            REQ: begin
                o_ireq_valid = 1'b1;
                o_ireq_addr  = pc_q;
            end
            WAIT: begin
                o_ireq_addr  = pc_q;
                o_irsp_ready = drop_q | ~out_valid_q | i_id_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q   <= RESET_PC;
            drop_q <= 1'b0;
        end else begin
            if (i_br_sel)  pc_q <= i_br_target;
            else if (load) pc_q <= pc_q + PC_WD'(4);
            if (rsp_hs)
                drop_q <= 1'b0;
            else if (i_br_sel && (req_hs || state_q == WAIT))
                drop_q <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
        end else begin
            if (i_br_sel)                      out_valid_q <= 1'b0;
            else if (load)                     out_valid_q <= 1'b1;
            else if (out_valid_q & i_id_ready) out_valid_q <= 1'b0;
            if (load) begin
                out_pc_q   <= pc_q;
                out_inst_q <= i_irsp_data;
            end
        end
    end

    assign o_if_valid = out_valid_q;
    assign o_if_pc    = out_pc_q;
    assign o_if_inst  = out_inst_q;

endmodule

// File: tb/tb_ysyx_22050710_ifu_pcgen.sv
// Bench for the IF PC generator: behavioural imem, redirect stimulus and
// a scoreboard of instructions expected at the ID side.
module tb_ysyx_22050710_ifu_pcgen;

    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_br_sel = 1'b0;
    logic [63:0] i_br_target = '0;
    logic        o_ireq_valid;
    logic        i_ireq_ready = 1'b0;
    logic [63:0] o_ireq_addr;
    logic        i_irsp_valid = 1'b0;
    logic        o_irsp_ready;
    logic [31:0] i_irsp_data = '0;
    logic        o_if_valid;
    logic        i_id_ready = 1'b0;
    logic [63:0] o_if_pc;
    logic [31:0] o_if_inst;

    ysyx_22050710_ifu_pcgen dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_br_sel     (i_br_sel),
        .i_br_target  (i_br_target),
        .o_ireq_valid (o_ireq_valid),
        .i_ireq_ready (i_ireq_ready),
        .o_ireq_addr  (o_ireq_addr),
        .i_irsp_valid (i_irsp_valid),
        .o_irsp_ready (o_irsp_ready),
        .i_irsp_data  (i_irsp_data),
        .o_if_valid   (o_if_valid),
        .i_id_ready   (i_id_ready),
        .o_if_pc      (o_if_pc),
        .o_if_inst    (o_if_inst)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          pending = 0;
    bit          cancelled = 0;
    bit          in_idle = 1;
    bit          req_rdy = 1;
    int          cnt = 0;
    int          lat = 0;
    logic [63:0] exp_addr = RST_PC;
    logic [63:0] pend_addr = '0;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [63:0] a);
        return a[31:0] ^ 32'h0000_0013;
    endfunction

    // one clock: drive imem, check, step the edge, update the model
    task automatic cyc();
        bit          req_hs;
        bit          rsp_hs;
        bit          id_hs;
        logic [63:0] a;
        i_ireq_ready = req_rdy;
        i_irsp_valid = pending && cnt == 0;
        i_irsp_data  = i_irsp_valid ? mem(pend_addr) : 32'h0;
        #1;
        chk("ireq_valid", o_ireq_valid, 64'(!in_idle && !pending));
        if (o_ireq_valid) chk("ireq_addr", o_ireq_addr, exp_addr);
        chk("irsp_ready", o_irsp_ready,
            64'(pending && (cancelled || sb.size() == 0 || i_id_ready)));
        chk("if_valid", o_if_valid, 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("if_pc", o_if_pc, sb[0].pc);
            chk("if_inst", 64'(o_if_inst), 64'(sb[0].inst));
        end
        req_hs = o_ireq_valid && i_ireq_ready;
        rsp_hs = i_irsp_valid && o_irsp_ready;
        id_hs  = o_if_valid && i_id_ready;
        a      = o_ireq_addr;
        @(posedge i_clk);
        #1;
        if (i_rst) begin
            sb.delete();
            pending   = 0;
            cancelled = 0;
            in_idle   = 1;
            exp_addr  = RST_PC;
            i_irsp_valid = 1'b0;
        end else begin
            in_idle = 0;
            if (id_hs && sb.size() != 0) void'(sb.pop_front());
            if (rsp_hs) begin
                if (!cancelled && !i_br_sel) begin
                    sb.push_back('{pend_addr, mem(pend_addr)});
                    exp_addr = pend_addr + 64'd4;
                end
                pending   = 0;
                cancelled = 0;
            end else if (pending && cnt > 0) begin
                cnt--;
            end
            if (req_hs) begin
                pending   = 1;
                cancelled = 0;
                pend_addr = a;
                cnt       = lat;
            end
            if (i_br_sel) begin
                sb.delete();
                exp_addr = i_br_target;
                if (pending) cancelled = 1;
            end
        end
    endtask

    task automatic redirect(input logic [63:0] t);
        i_br_sel    = 1'b1;
        i_br_target = t;
        cyc();
        i_br_sel    = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] stall_pc;

        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        chk("idle_ireq_valid", o_ireq_valid, 0);
        chk("idle_irsp_ready", o_irsp_ready, 0);
        chk("idle_if_valid", o_if_valid, 0);
        chk("idle_addr", o_ireq_addr, 0);
        chk("idle_if_pc", o_if_pc, 0);
        chk("idle_if_inst", 64'(o_if_inst), 0);

        // streaming with zero-wait memory
        i_id_ready = 1'b1;
        cyc();
        chk("first_addr", o_ireq_addr, RST_PC);
        repeat (8) cyc();

        // ID stall with a buffered instruction and a response waiting
        i_id_ready = 1'b0;
        n = 0;
        while (!(sb.size() != 0 && pending && cnt == 0) && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_stall", 64'(sb.size() != 0 && pending), 1);
        stall_pc = sb.size() != 0 ? sb[0].pc : '0;
        repeat (3) cyc();
        chk("stall_rdy", o_irsp_ready, 0);
        chk("stall_hold", o_if_pc, stall_pc);
        i_id_ready = 1'b1;
        cyc();
        chk("release_pc", o_if_pc, stall_pc + 64'd4);
        chk("release_valid", o_if_valid, 1);

        // redirect while waiting on a slow response
        lat = 3;
        n = 0;
        while (!(pending && !cancelled) && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_inflight", 64'(pending), 1);
        redirect(64'h8000_1000);
        n = 0;
        while (!o_ireq_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_redir_req", o_ireq_valid, 1);
        chk("redir_wait_addr", o_ireq_addr, 64'h8000_1000);
        chk("redir_wait_nobuf", o_if_valid, 0);

        // redirect in REQ without accept, then colliding with accept
        req_rdy = 0;
        lat = 1;
        redirect(64'h8000_0010);
        chk("req_redir_addr", o_ireq_addr, 64'h8000_0010);
        req_rdy = 1;
        redirect(64'h8000_2000);
        n = 0;
        while (!o_ireq_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("collide_addr", o_ireq_addr, 64'h8000_2000);
        chk("collide_nobuf", o_if_valid, 0);

        // redirect flushes a valid buffer even with ID ready
        lat = 0;
        n = 0;
        while (!o_if_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_buf", o_if_valid, 1);
        redirect(64'h8000_3000);
        chk("flush_valid", o_if_valid, 0);
        n = 0;
        while (!o_if_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("newpath_pc", o_if_pc, 64'h8000_3000);

        // reset in WAIT with a valid buffer
        i_id_ready = 1'b0;
        lat = 4;
        n = 0;
        while (!(o_if_valid && pending) && n < 50) begin
            cyc();
            n++;
        end
        chk("wait_rst_cond", 64'(o_if_valid && pending), 1);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        chk("rst_if_valid", o_if_valid, 0);
        chk("rst_ireq_valid", o_ireq_valid, 0);
        chk("rst_addr", o_ireq_addr, 0);
        cyc();
        chk("rst_req_valid", o_ireq_valid, 1);
        chk("rst_req_addr", o_ireq_addr, RST_PC);

        // PC wrap at the top of the address space
        i_id_ready = 1'b1;
        lat = 0;
        req_rdy = 0;
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        req_rdy = 1;
        n = 0;
        while (!o_if_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("wrap_pc", o_if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        n = 0;
        while (!o_ireq_valid && n < 50) begin
            cyc();
            n++;
        end
        chk("wrap_addr", o_ireq_addr, 64'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            i_id_ready = 1'($urandom_range(0, 1));
            req_rdy    = ($urandom_range(0, 3) != 0);
            if (!pending) lat = $urandom_range(0, 3);
            if ($urandom_range(0, 11) == 0)
                redirect({32'h8000_0000, 20'h0, 10'($urandom), 2'b00});
            else
                cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
